// File: rtl/stack_sequencer.sv
// Hardware call/return/interrupt stack engine: moves the PC (as two 16-bit halves)
// and, for interrupts, the flags between the core and a 16-bit data memory.
module stack_sequencer #(
  parameter logic [31:0] SP_INIT = 32'h0000_0FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call,
  input  logic        ret,
  input  logic        rti,
  input  logic        interrupt,
  input  logic [31:0] pc_in,
  input  logic [2:0]  ccr_in,
  input  logic [15:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic        stall,
  output logic [31:0] pc_out,
  output logic        pc_load,
  output logic [2:0]  ccr_out,
  output logic        ccr_load,
  output logic        int_ack,
  output logic [31:0] sp
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, POP_CCR, POP_LO, POP_HI, FINISH
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] sp_q, pc_lat;
  logic [2:0]  ccr_lat, ccr_pop;
  logic [15:0] lo_q;
  logic        int_pending, is_int, is_rti;
  logic        accept, take_int, take_rti;

  // Request semantics: call/ret/rti/interrupt are sampled only while IDLE; the
  // highest-priority one is accepted and the rest are dropped. An interrupt seen
  // while busy is remembered in int_pending and served at the next IDLE cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take_int  = 1'b0;
    take_rti  = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (interrupt || int_pending) begin
            accept = 1'b1; take_int = 1'b1; state_nxt = PUSH_HI;
          end else if (rti) begin
            accept = 1'b1; take_rti = 1'b1; state_nxt = POP_CCR;
          end else if (ret) begin
            accept = 1'b1; state_nxt = POP_LO;
          end else if (call) begin
            accept = 1'b1; state_nxt = PUSH_HI;
          end
        end
      end
      PUSH_HI:  state_nxt = PUSH_LO;
      PUSH_LO:  state_nxt = is_int ? PUSH_CCR : IDLE;
      PUSH_CCR: state_nxt = IDLE;
      POP_CCR:  state_nxt = POP_LO;
      POP_LO:   state_nxt = POP_HI;
      POP_HI:   state_nxt = FINISH;
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Every output is forced low while rst is high, whatever state was left behind.
  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pc_out    = '0;
    pc_load   = 1'b0;
    ccr_out   = '0;
    ccr_load  = 1'b0;
    int_ack   = 1'b0;
    stall     = !rst && ((state != IDLE) || accept);
    if (!rst) begin
      case (state)
        PUSH_HI: begin
          mem_wr = 1'b1; mem_addr = sp_q; mem_wdata = pc_lat[31:16];
        end
        PUSH_LO: begin
          mem_wr = 1'b1; mem_addr = sp_q; mem_wdata = pc_lat[15:0];
        end
        PUSH_CCR: begin
          mem_wr = 1'b1; mem_addr = sp_q; mem_wdata = {13'b0, ccr_lat}; int_ack = 1'b1;
        end
        POP_CCR, POP_LO, POP_HI: begin
          mem_rd = 1'b1; mem_addr = sp_q + 32'd1;
        end
        FINISH: begin
          pc_load  = 1'b1;
          pc_out   = {mem_rdata, lo_q};
          ccr_load = is_rti;
          ccr_out  = is_rti ? ccr_pop : 3'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sp_q        <= SP_INIT;
      int_pending <= 1'b0;
      pc_lat      <= '0;
      ccr_lat     <= '0;
      ccr_pop     <= '0;
      lo_q        <= '0;
      is_int      <= 1'b0;
      is_rti      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_wr)      sp_q <= sp_q - 32'd1;
      else if (mem_rd) sp_q <= sp_q + 32'd1;
      if (accept) begin
        pc_lat  <= pc_in;
        ccr_lat <= ccr_in;
        is_int  <= take_int;
        is_rti  <= take_rti;
      end
      if (take_int)                            int_pending <= 1'b0;
      else if (interrupt && (state != IDLE))   int_pending <= 1'b1;
      // Read data lags its strobe by one cycle, so each pop state captures the
      // word requested by the previous one.
      if (state == POP_LO && is_rti) ccr_pop <= mem_rdata[2:0];
      if (state == POP_HI)           lo_q    <= mem_rdata;
    end
  end

  assign sp = sp_q;

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter SP_INIT, default 32'h0000_0FFF, meaning stack pointer value after reset.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port call, input, 1, CALL decoded in the current instruction.
REQ-005 SHALL have port ret, input, 1, RET decoded.
REQ-006 SHALL have port rti, input, 1, RTI decoded.
REQ-007 SHALL have port interrupt, input, 1, external interrupt request (level).
REQ-008 SHALL have port pc_in, input, 32, return address to push.
REQ-009 SHALL have port ccr_in, input, 3, flags {C,N,Z} to push on interrupt.
REQ-010 SHALL have port mem_rdata, input, 16, data memory read data, valid one cycle after mem_rd.
REQ-011 SHALL have port mem_addr, output, 32, data memory word address.
REQ-012 SHALL have port mem_wdata, output, 16, data memory write data.
REQ-013 SHALL have ports mem_wr and mem_rd, outputs, 1 each, write/read strobes, never both high.
REQ-014 SHALL have port stall, output, 1, freeze fetch/decode.
REQ-015 SHALL have ports pc_out (32) and pc_load (1), outputs, popped PC and its load strobe.
REQ-016 SHALL have ports ccr_out (3) and ccr_load (1), outputs, popped flags and load strobe.
REQ-017 SHALL have port int_ack, output, 1, one-cycle pulse when the interrupt push completes.
REQ-018 SHALL have port sp, output, 32, current stack pointer.

Function
REQ-019 SHALL implement states IDLE, PUSH_HI, PUSH_LO, PUSH_CCR, POP_CCR, POP_LO, POP_HI, FINISH.
REQ-020 SHALL accept a request only in IDLE, priority interrupt-or-pending > rti > ret > call; lower requests in the same cycle are dropped.
REQ-021 SHALL latch pc_in and ccr_in into internal registers at acceptance.
REQ-022 SHALL set int_pending when interrupt is high outside IDLE and clear it when the interrupt is accepted.
REQ-023 SHALL drive stall = (state != IDLE) OR (request accepted this cycle).
REQ-024 Push cycle: mem_wr=1, mem_addr=sp, sp <= sp-1; stack grows downward.
REQ-025 Pop cycle: mem_rd=1, mem_addr=sp+1, sp <= sp+1.
REQ-026 CALL: IDLE -> PUSH_HI (pc[31:16]) -> PUSH_LO (pc[15:0]) -> IDLE; 2 stall cycles.
REQ-027 Interrupt: PUSH_HI -> PUSH_LO -> PUSH_CCR (wdata {13'b0,ccr}) -> IDLE; int_ack=1 in PUSH_CCR.
REQ-028 RET: POP_LO -> POP_HI (capture mem_rdata as low half) -> FINISH (pc_out={mem_rdata,lo}, pc_load=1) -> IDLE.
REQ-029 RTI: POP_CCR -> POP_LO (capture ccr=mem_rdata[2:0]) -> POP_HI -> FINISH (pc_load=1, ccr_load=1) -> IDLE.
REQ-030 SHALL hold mem_wr, mem_rd, pc_load, ccr_load, int_ack at 0 in all other states.
REQ-031 SP arithmetic SHALL be 32-bit modulo 2^32; no overflow/underflow detection.
REQ-032 SHALL accept a new request in the IDLE cycle immediately following any sequence.

Reset
REQ-033 On rst high at a clock edge: state=IDLE, sp=SP_INIT, int_pending=0, latched registers=0, regardless of sequence in progress.
REQ-034 During and after reset all strobes, stall, pc_out, ccr_out, mem_addr, mem_wdata SHALL be 0 until a request is accepted.

Verification
REQ-035 call=1, pc_in=32'h0001_2345, sp=0xFFF -> writes M[0xFFF]=0x0001, M[0xFFE]=0x2345; sp=0xFFD; stall 2 cycles.
REQ-036 ret after REQ-035 -> reads 0xFFE then 0xFFF; FINISH pc_out=32'h0001_2345, pc_load=1; sp=0xFFF; stall 3 cycles.
REQ-037 interrupt, pc_in=32'h0000_0100, ccr_in=3'b101 -> M[0xFFF]=0, M[0xFFE]=0x0100, M[0xFFD]=0x0005, int_ack in 3rd cycle; then rti -> ccr_out=3'b101, pc_out=32'h0000_0100, sp=0xFFF.
REQ-038 call and interrupt same cycle -> interrupt sequence only; interrupt pulsed during CALL push -> interrupt sequence starts in the IDLE cycle after PUSH_LO.
REQ-039 rst asserted in POP_HI of RET -> next cycle IDLE, sp=0xFFF, pc_load never asserted.
REQ-040 sp=0 with call -> writes M[0], M[0xFFFF_FFFF]; sp wraps to 0xFFFF_FFFE.
